tristate_buf: RTL and testbench

//   Registered tri-state output driver for a shared single-driver bus segment.
//   - Samples data (sin) and drive-enable request (ena) on each clock edge.
//   - Drives the captured data onto sout while enabled; releases sout to high-Z otherwise.
//   - Inserts a programmable bus-turnaround guard after every release.

---
 rtl/tristate_pkg.sv | 19 +
 rtl/tristate_guard.sv | 48 ++++
 rtl/tristate_buf.sv | 95 +++++++++
 tb/tb_tristate_buf.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tristate_pkg.sv
// Shared definitions for the registered tri-state bus driver.
//   GUARD_W : width of the bus-turnaround guard counter
//   DCNT_W  : width of the optional driven-cycle counter
//   z_bus() : all-Z bus value (bits at or above 'width' are returned as 0)
package tristate_pkg;

  localparam int GUARD_W = 4;
  localparam int DCNT_W  = 16;
  localparam int Z_MAX_W = 256;

  function automatic logic [Z_MAX_W-1:0] z_bus(input int width);
    logic [Z_MAX_W-1:0] r;
    for (int i = 0; i < Z_MAX_W; i++) begin
      r[i] = (i < width) ? 1'bz : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/tristate_guard.sv
// Bus-turnaround guard for tristate_buf.
// After every release of the bus (en_q falling), it refuses new drive
// requests for TURN_CYC clock edges so that another driver can get off
// the segment first.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   ena        : drive request sampled this edge
//   en_q       : current effective drive enable (from the top level)
//   grant      : 1 when a drive request may be accepted this edge
module tristate_guard
  import tristate_pkg::*;
#(
  parameter int TURN_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic en_q,
  output logic grant
);

  localparam logic [GUARD_W-1:0] TURN_LD = GUARD_W'(TURN_CYC);

  logic [GUARD_W-1:0] guard_q;
  logic [GUARD_W-1:0] guard_d;

  // A release is the edge that samples ena=0 while still driving; the
  // guard reloads there, otherwise it counts down and parks at zero.
  always_comb begin
    guard_d = guard_q;
    if (en_q && !ena) begin
      guard_d = TURN_LD;
    end else if (guard_q != '0) begin
      guard_d = guard_q - GUARD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guard_q <= '0;
    end else begin
      guard_q <= guard_d;
    end
  end

  assign grant = (guard_q == '0);

endmodule

// File: rtl/tristate_buf.sv
// Registered tri-state output driver for a shared single-driver bus segment.
// sin and ena are registered every edge; sout is driven from the registered
// data while the registered enable is set and is high-Z otherwise, so sout
// follows the inputs one clock later and has no combinational input path.
// A turnaround guard (tristate_guard) blocks re-drive for TURN_CYC edges
// after every release.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset; forces sout to Z
//   sin   : data to place on the bus
//   ena   : drive request (1 = drive, 0 = release)
//   sout  : tri-state bus output
// Optional (macro TRIST_STATUS_EN):
//   drv   : 1 while sout is actively driven
//   dcnt  : wrapping count of driven cycles
module tristate_buf
  import tristate_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  sin,
  input  logic              ena,
  output tri logic [WIDTH-1:0] sout
`ifdef TRIST_STATUS_EN
  ,
  output logic              drv,
  output logic [DCNT_W-1:0] dcnt
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             en_q;
  logic             en_d;
  logic             grant;

  tristate_guard #(
    .TURN_CYC (TURN_CYC)
  ) u_guard (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .en_q  (en_q),
    .grant (grant)
  );

  // Data is captured unconditionally (X/Z included); a request is only
  // honoured once the guard has expired.
  always_comb begin
    data_d = sin;
    en_d   = ena && grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      en_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  // Driven purely from registers; the literal Z form keeps the driver a
  // plain conditional tri-state buffer.
  assign sout = en_q ? data_q : {WIDTH{1'bz}};

`ifdef TRIST_STATUS_EN
  logic [DCNT_W-1:0] dcnt_q;
  logic [DCNT_W-1:0] dcnt_d;

  // Counts edges at which the bus was driven; wraps naturally.
  always_comb begin
    dcnt_d = dcnt_q;
    if (en_q) begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign drv  = en_q;
  assign dcnt = dcnt_q;
`endif

endmodule

// File: tb/tb_tristate_buf.sv
// Directed bench for tristate_buf.
// Each configuration is instantiated twice on identical stimulus: one copy
// feeds a pulled-up net, the other a pulled-down net. A released bus reads
// all-ones on the first and all-zeros on the second; a driven bus reads the
// same value on both. TURN_CYC=1 and TURN_CYC=0 are both exercised.
module tb_tristate_buf;

  localparam int W  = 4;
  localparam int ZC = -1;   // code for a released (high-Z) bus
  localparam int XC = -2;   // code for an inconsistent reading

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sin;
  logic         ena;

  wire [W-1:0] bus_t1_hi;
  wire [W-1:0] bus_t1_lo;
  wire [W-1:0] bus_t0_hi;
  wire [W-1:0] bus_t0_lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_pull
    pullup   (bus_t1_hi[i]);
    pulldown (bus_t1_lo[i]);
    pullup   (bus_t0_hi[i]);
    pulldown (bus_t0_lo[i]);
  end

`ifdef TRIST_STATUS_EN
  logic        drv_a, drv_b, drv_c, drv_d;
  logic [15:0] dcnt_a, dcnt_b, dcnt_c, dcnt_d;
`endif

  tristate_buf #(.WIDTH(W), .TURN_CYC(1)) u_t1_hi (
    .clk(clk), .reset(reset), .sin(sin), .ena(ena), .sout(bus_t1_hi)
`ifdef TRIST_STATUS_EN
    , .drv(drv_a), .dcnt(dcnt_a)
`endif
  );
  tristate_buf #(.WIDTH(W), .TURN_CYC(1)) u_t1_lo (
    .clk(clk), .reset(reset), .sin(sin), .ena(ena), .sout(bus_t1_lo)
`ifdef TRIST_STATUS_EN
    , .drv(drv_b), .dcnt(dcnt_b)
`endif
  );
  tristate_buf #(.WIDTH(W), .TURN_CYC(0)) u_t0_hi (
    .clk(clk), .reset(reset), .sin(sin), .ena(ena), .sout(bus_t0_hi)
`ifdef TRIST_STATUS_EN
    , .drv(drv_c), .dcnt(dcnt_c)
`endif
  );
  tristate_buf #(.WIDTH(W), .TURN_CYC(0)) u_t0_lo (
    .clk(clk), .reset(reset), .sin(sin), .ena(ena), .sout(bus_t0_lo)
`ifdef TRIST_STATUS_EN
    , .drv(drv_d), .dcnt(dcnt_d)
`endif
  );

  function automatic int bus_code(input logic [W-1:0] hi, input logic [W-1:0] lo);
    if (hi == lo) return int'(hi);
    if (hi == '1 && lo == '0) return ZC;
    return XC;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (-1 = Z)", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bus(input string tag, input int e1, input int e0);
    check({tag, "_t1"}, bus_code(bus_t1_hi, bus_t1_lo), e1);
    check({tag, "_t0"}, bus_code(bus_t0_hi, bus_t0_lo), e0);
  endtask

  initial begin
    // 1: reset with drive requested
    reset = 1'b1; sin = 4'hF; ena = 1'b1;
    tick(); expect_bus("rst_c1", ZC, ZC);
    tick(); expect_bus("rst_c2", ZC, ZC);
    reset = 1'b0;
    tick(); expect_bus("post_rst", 15, 15);

    // 2: released bus ignores data
    ena = 1'b0;
    sin = 4'h0; tick(); expect_bus("rel_0", ZC, ZC);
    sin = 4'hF; tick(); expect_bus("rel_1", ZC, ZC);
    sin = 4'h0; tick(); expect_bus("rel_2", ZC, ZC);
    sin = 4'hF; tick(); expect_bus("rel_3", ZC, ZC);

    // 3: continuous drive, data one cycle late
    ena = 1'b1;
    sin = 4'h0; tick(); expect_bus("drv_0", 0, 0);
    sin = 4'hA; tick(); expect_bus("drv_A", 10, 10);
    sin = 4'h5; tick(); expect_bus("drv_5", 5, 5);
    sin = 4'h3; tick(); expect_bus("drv_3", 3, 3);

    // 4: release then immediate re-request
    sin = 4'h7;
    ena = 1'b1; tick(); expect_bus("turn_a", 7, 7);
    ena = 1'b0; tick(); expect_bus("turn_b", ZC, ZC);
    ena = 1'b1; tick(); expect_bus("turn_c", ZC, 7);
    ena = 1'b1; tick(); expect_bus("turn_d", 7, 7);

    // reset landing inside the guard window
    ena = 1'b0; tick(); expect_bus("grst_rel", ZC, ZC);
    reset = 1'b1; ena = 1'b1; tick(); expect_bus("grst_rst", ZC, ZC);
    reset = 1'b0; sin = 4'h9; tick(); expect_bus("grst_drv", 9, 9);

    // 5: reset pulse while driving
    sin = 4'hF; reset = 1'b1; tick(); expect_bus("rst_mid", ZC, ZC);
    reset = 1'b0; ena = 1'b0; tick(); expect_bus("rst_mid_rel", ZC, ZC);

`ifdef TRIST_STATUS_EN
    // 6: status outputs
    reset = 1'b1; tick();
    check("dcnt_rst", int'(dcnt_a), 0);
    check("drv_rst", int'(drv_a), 0);
    reset = 1'b0; ena = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("drv_on", int'(drv_a), 1);
    check("dcnt_4", int'(dcnt_a), 4);
    ena = 1'b0; tick();
    check("drv_off", int'(drv_a), 0);
    check("dcnt_5", int'(dcnt_a), 5);
    tick();
    check("dcnt_hold", int'(dcnt_a), 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
